// File: rtl/hazard_pkg.sv
// Shared constants, types and helpers for the hazard scheduler and its
// scoreboard entries.
package hazard_pkg;

  // Number of architectural registers tracked by the scoreboard.
  localparam int REG_CNT  = 32;
  // Width of each scoreboard down-counter.
  localparam int SB_CNT_W = 2;
  // Number of cycles from issue (leaving ID) to the WB stage.
  localparam int WB_DIST  = 3;

  // Cycles a freshly issued writer keeps its destination busy. With the
  // register file forwarding the WB data on a same-cycle read, the consumer
  // may read during the producer's WB cycle; without it, one more cycle is
  // needed.
  function automatic logic [SB_CNT_W-1:0] cnt_init(input bit rf_bypass);
    return rf_bypass ? SB_CNT_W'(2) : SB_CNT_W'(3);
  endfunction

  // Enable and flush controls for the front-end pipeline registers.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/hazard_sched_sb_entry.sv
// One scoreboard entry: a small down-counter that tracks how long the
// register it guards still has a write in flight.
module sb_entry
  import hazard_pkg::*;
#(
  parameter logic [SB_CNT_W-1:0] INIT = SB_CNT_W'(2)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_busy
);

  logic [SB_CNT_W-1:0] cnt_q;
  logic [SB_CNT_W-1:0] cnt_d;

  // A new writer reloads the counter (the youngest writer wins); otherwise
  // the count drains by one per cycle because downstream stages never stall.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = INIT;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register; reset discards any pending write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_sched.sv
// Issue scheduler and hazard controller for a 5-stage non-forwarding
// pipeline. Holds the ID instruction until its sources are written back,
// applies EX redirects, and tracks issued instructions through to WB.
module hazard_sched
  import hazard_pkg::*;
#(
  parameter bit RF_BYPASS = 1'b1,
  parameter int PERF_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_vld,
  input  logic [4:0]        i_id_rs1_addr,
  input  logic              i_id_rs1_used,
  input  logic [4:0]        i_id_rs2_addr,
  input  logic              i_id_rs2_used,
  input  logic [4:0]        i_id_rd_addr,
  input  logic              i_id_rd_wren,
  input  logic              i_ex_redirect,
  output logic              o_pc_en,
  output logic              o_ifid_en,
  output logic              o_ifid_flush,
  output logic              o_idex_flush,
  output logic              o_issue,
  output logic              o_stall,
  output logic              o_retire,
  output logic [31:0]       o_busy_mask,
  output logic [PERF_W-1:0] o_stall_cnt
);

  localparam logic [SB_CNT_W-1:0] CNT_INIT = cnt_init(RF_BYPASS);

  logic [REG_CNT-1:0] busy_raw;
  logic [REG_CNT-1:1] load_vec;
  logic               rs1_hit;
  logic               rs2_hit;
  logic               raw;
  logic               issue;
  logic               stall;
  pipe_ctrl_t         ctrl;

  logic [WB_DIST-1:0] retire_q;
  logic [WB_DIST-1:0] retire_d;
  logic [PERF_W-1:0]  stall_cnt_q;
  logic [PERF_W-1:0]  stall_cnt_d;

  // x0 is hard-wired to zero and can never be pending.
  assign busy_raw[0] = 1'b0;

  generate
    for (genvar r = 1; r < REG_CNT; r++) begin : g_sb
      sb_entry #(
        .INIT (CNT_INIT)
      ) u_sb (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (load_vec[r]),
        .o_busy (busy_raw[r])
      );
    end
  endgenerate

  // RAW detection and per-cycle priority: reset, then EX redirect, then
  // RAW stall, then normal flow (an invalid ID slot flows as a bubble).
  always_comb begin
    rs1_hit = i_id_rs1_used && (i_id_rs1_addr != 5'd0) && busy_raw[i_id_rs1_addr];
    rs2_hit = i_id_rs2_used && (i_id_rs2_addr != 5'd0) && busy_raw[i_id_rs2_addr];
    raw     = i_id_vld && (rs1_hit || rs2_hit);
    ctrl    = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
    issue   = 1'b0;
    stall   = 1'b0;
    if (i_rst) begin
      ctrl = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
    end else if (i_ex_redirect) begin
      ctrl = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
    end else if (raw) begin
      ctrl  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
      stall = 1'b1;
    end else begin
      ctrl  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
      issue = i_id_vld;
    end
  end

  // Scoreboard load strobes: only an instruction that actually issues and
  // writes a real register marks that register pending.
  always_comb begin
    load_vec = '0;
    for (int r = 1; r < REG_CNT; r++) begin
      load_vec[r] = issue && i_id_rd_wren && (i_id_rd_addr == 5'(r));
    end
  end

  // Next-state for the retire pipe and the saturating stall counter.
  always_comb begin
    retire_d    = {retire_q[WB_DIST-2:0], issue};
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  // Retire shift register and stall counter; reset drops anything in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      retire_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      retire_q    <= retire_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_pc_en      = ctrl.pc_en;
  assign o_ifid_en    = ctrl.ifid_en;
  assign o_ifid_flush = ctrl.ifid_flush;
  assign o_idex_flush = ctrl.idex_flush;
  assign o_issue      = issue;
  assign o_stall      = stall;
  assign o_retire     = i_rst ? 1'b0 : retire_q[WB_DIST-1];
  assign o_busy_mask  = i_rst ? '0 : busy_raw;
  assign o_stall_cnt  = i_rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched. Two instances share one stimulus
// stream: one with register-file bypass and a wide perf counter, one without
// bypass and with a 3-bit perf counter so saturation is reached.
module tb_hazard_sched;

  logic       clk = 1'b0;
  logic       rst, vld, u1, u2, wr, redir;
  logic [4:0] rs1, rs2, rd;

  logic        pc_en[2], ifid_en[2], ifid_flush[2], idex_flush[2];
  logic        issue[2], stall[2], retire[2];
  logic [31:0] bmask[2];
  logic [31:0] scnt0;
  logic [2:0]  scnt1;

  int total    = 0;
  int bad      = 0;
  int cyc      = 0;
  int last_rst = -100;

  // Reference state: cycle from which each register reads as written back,
  // perf count, and which cycles issued an instruction.
  int ready[2][32];
  int scnt[2];
  bit issued[2][4096];

  always #5 clk = ~clk;

  hazard_sched #(.RF_BYPASS(1'b1), .PERF_W(32)) u_byp (
    .i_clk(clk), .i_rst(rst), .i_id_vld(vld),
    .i_id_rs1_addr(rs1), .i_id_rs1_used(u1),
    .i_id_rs2_addr(rs2), .i_id_rs2_used(u2),
    .i_id_rd_addr(rd), .i_id_rd_wren(wr), .i_ex_redirect(redir),
    .o_pc_en(pc_en[0]), .o_ifid_en(ifid_en[0]), .o_ifid_flush(ifid_flush[0]),
    .o_idex_flush(idex_flush[0]), .o_issue(issue[0]), .o_stall(stall[0]),
    .o_retire(retire[0]), .o_busy_mask(bmask[0]), .o_stall_cnt(scnt0)
  );

  hazard_sched #(.RF_BYPASS(1'b0), .PERF_W(3)) u_nob (
    .i_clk(clk), .i_rst(rst), .i_id_vld(vld),
    .i_id_rs1_addr(rs1), .i_id_rs1_used(u1),
    .i_id_rs2_addr(rs2), .i_id_rs2_used(u2),
    .i_id_rd_addr(rd), .i_id_rd_wren(wr), .i_ex_redirect(redir),
    .o_pc_en(pc_en[1]), .o_ifid_en(ifid_en[1]), .o_ifid_flush(ifid_flush[1]),
    .o_idex_flush(idex_flush[1]), .o_issue(issue[1]), .o_stall(stall[1]),
    .o_retire(retire[1]), .o_busy_mask(bmask[1]), .o_stall_cnt(scnt1)
  );

  task automatic chk(input string tag, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("[TB] FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", tag, k, cyc, act, exp);
    end
  endtask

  // Compare both instances against the reference for the current cycle,
  // then advance the reference across the coming clock edge.
  task automatic checkOutput();
    logic [31:0] ebm;
    logic        eraw, epc, eifen, eifl, eidf, eiss, est, eret;
    logic [31:0] ecnt, acnt;
    int          init_v, smax;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      init_v = (k == 0) ? 2 : 3;
      smax   = (k == 0) ? 32'h7fff_ffff : 7;
      ebm = '0;
      if (!rst) begin
        for (int r = 1; r < 32; r++) ebm[r] = (cyc < ready[k][r]);
      end
      eraw = vld && ((u1 && rs1 != 0 && ebm[rs1]) || (u2 && rs2 != 0 && ebm[rs2]));
      eiss = 1'b0;
      est  = 1'b0;
      if (rst) begin
        {epc, eifen, eifl, eidf} = 4'b0011;
      end else if (redir) begin
        {epc, eifen, eifl, eidf} = 4'b1111;
      end else if (eraw) begin
        {epc, eifen, eifl, eidf} = 4'b0001;
        est = 1'b1;
      end else begin
        {epc, eifen, eifl, eidf} = 4'b1100;
        eiss = vld;
      end
      eret = !rst && (cyc >= 3) && issued[k][cyc-3] && (last_rst < cyc - 2);
      ecnt = rst ? 32'd0 : 32'(scnt[k]);
      acnt = (k == 0) ? scnt0 : {29'd0, scnt1};

      chk("pc_en",      k, {31'd0, pc_en[k]},      {31'd0, epc});
      chk("ifid_en",    k, {31'd0, ifid_en[k]},    {31'd0, eifen});
      chk("ifid_flush", k, {31'd0, ifid_flush[k]}, {31'd0, eifl});
      chk("idex_flush", k, {31'd0, idex_flush[k]}, {31'd0, eidf});
      chk("issue",      k, {31'd0, issue[k]},      {31'd0, eiss});
      chk("stall",      k, {31'd0, stall[k]},      {31'd0, est});
      chk("retire",     k, {31'd0, retire[k]},     {31'd0, eret});
      chk("busy_mask",  k, bmask[k],               ebm);
      chk("stall_cnt",  k, acnt,                   ecnt);

      if (rst) begin
        for (int r = 0; r < 32; r++) ready[k][r] = 0;
        scnt[k] = 0;
        issued[k][cyc] = 1'b0;
      end else begin
        issued[k][cyc] = eiss;
        if (eiss && wr && rd != 0) ready[k][rd] = cyc + init_v + 1;
        if (est && scnt[k] < smax) scnt[k]++;
      end
    end
    if (rst) last_rst = cyc;
    cyc++;
  endtask

  task automatic applyStimulus(input logic r, input logic v,
                               input logic [4:0] a1, input logic b1,
                               input logic [4:0] a2, input logic b2,
                               input logic [4:0] d, input logic w,
                               input logic x);
    @(posedge clk);
    #1;
    rst = r; vld = v; rs1 = a1; u1 = b1; rs2 = a2; u2 = b2;
    rd = d; wr = w; redir = x;
    checkOutput();
  endtask

  task automatic instr(input logic [4:0] a1, input logic b1,
                       input logic [4:0] a2, input logic b2,
                       input logic [4:0] d, input logic w);
    applyStimulus(1'b0, 1'b1, a1, b1, a2, b2, d, w, 1'b0);
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; rs1 = '0; u1 = 1'b0; rs2 = '0; u2 = 1'b0;
    rd = '0; wr = 1'b0; redir = 1'b0;
    for (int k = 0; k < 2; k++) begin
      scnt[k] = 0;
      for (int r = 0; r < 32; r++) ready[k][r] = 0;
    end

    // Reset for two cycles with arbitrary inputs.
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1,
                    5'($urandom), 1'b1, 1'($urandom));
    bubbles(1);

    // add x5,x1,x2 then sub x6,x5,x1 held in ID.
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1);
    for (int i = 0; i < 4; i++) instr(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1);
    bubbles(6);

    // x0 producer and consumer, then an unused busy rs2.
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1);
    instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1);
    bubbles(1);
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1);
    instr(5'd3, 1'b1, 5'd9, 1'b0, 5'd10, 1'b1);
    bubbles(4);

    // Redirect while a dependent would stall on x5.
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b1);
    bubbles(4);

    // WAW on x7 draining normally.
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1);
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1);
    instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1);
    instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1);
    instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1);
    bubbles(5);

    // WAW on x7 interrupted by reset.
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1);
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bubbles(5);

    // Randomized traffic over a small register set to provoke hazards.
    for (int i = 0; i < 500; i++)
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
                    5'($urandom_range(0, 7)), 1'($urandom),
                    5'($urandom_range(0, 7)), 1'($urandom),
                    5'($urandom_range(0, 7)), 1'($urandom),
                    ($urandom_range(0, 7) == 0));
    bubbles(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Issue scheduler and hazard controller for the 5-stage non-forwarding RV32I pipeline (IF, ID, EX, MEM, WB).
- Keeps a per-register scoreboard of in-flight writes. Stalls an ID instruction until every source it reads has been written back.
- Applies control-flow flushes from EX and produces the retire-valid strobe that drives the core's instruction-valid debug output.
- Sits beside the pipeline registers and drives their enable and flush inputs.

Parameters:
- RF_BYPASS, 1, 1 = register file returns the WB write data on a same-cycle read; 0 = no internal bypass.
- PERF_W, 32, width of the stall-cycle performance counter.

Ports:
- i_clk  in  1  core clock; all state updates on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_id_vld  in  1  ID stage holds a valid instruction.
- i_id_rs1_addr  in  5  rs1 index of the ID instruction.
- i_id_rs1_used  in  1  ID instruction reads rs1.
- i_id_rs2_addr  in  5  rs2 index.
- i_id_rs2_used  in  1  ID instruction reads rs2.
- i_id_rd_addr  in  5  rd index.
- i_id_rd_wren  in  1  ID instruction writes rd.
- i_ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- o_pc_en  out  1  PC register load enable.
- o_ifid_en  out  1  IF/ID register enable.
- o_ifid_flush  out  1  clear IF/ID to a bubble.
- o_idex_flush  out  1  insert a bubble into ID/EX.
- o_issue  out  1  ID instruction advances to EX this cycle.
- o_stall  out  1  RAW hazard stall this cycle.
- o_retire  out  1  an issued instruction is in WB this cycle.
- o_busy_mask  out  32  bit r = 1 while register r has a pending write.
- o_stall_cnt  out  PERF_W  saturating count of stall cycles.

Behaviour:
- **Reset.** While i_rst = 1:
  - all scoreboard counters cleared; retire shift register cleared; o_stall_cnt = 0.
  - o_pc_en = 0, o_ifid_en = 0, o_ifid_flush = 1, o_idex_flush = 1.
  - o_issue = 0, o_stall = 0, o_retire = 0, o_busy_mask = 0.
  - A reset asserted mid-operation discards all pending hazards in the same edge.
- **Scoreboard.** 32 entries, each a 2-bit down-counter.
  - Entry 0 (x0) is never written and always reads 0.
  - CNT_INIT = 2 if RF_BYPASS = 1, else 3.
  - Every cycle, each nonzero counter decrements by 1, whether or not the pipeline is stalled. Downstream stages always flow.
  - On an issue with i_id_rd_wren = 1 and rd != 0, counter[rd] loads CNT_INIT. The load overrides that entry's decrement (WAW: the younger writer wins).
  - o_busy_mask[r] = (counter[r] != 0), a combinational function of state.
- **Hazard.** raw = i_id_vld & ((rs1_used & rs1 != 0 & busy[rs1]) | (rs2_used & rs2 != 0 & busy[rs2])).
- **Priority, per cycle (combinational outputs):**
  1. i_ex_redirect = 1 (the redirect takes precedence over a simultaneous RAW stall):
     - o_pc_en = 1, o_ifid_en = 1, o_ifid_flush = 1, o_idex_flush = 1.
     - o_issue = 0, o_stall = 0; no scoreboard load.
  2. raw = 1:
     - o_pc_en = 0, o_ifid_en = 0, o_idex_flush = 1, o_ifid_flush = 0.
     - o_stall = 1, o_issue = 0.
  3. Otherwise:
     - o_pc_en = 1, o_ifid_en = 1, both flushes 0.
     - o_issue = i_id_vld.
     - An invalid ID slot still advances, as a bubble.
- **Latency.** A producer issues at cycle t (EX at t+1, WB at t+3). A dependent held in ID:
  - issues at t+3 with RF_BYPASS = 1 (2 stall cycles);
  - issues at t+4 with RF_BYPASS = 0 (3 stall cycles).
- **Retire.** 3-bit shift register; bit 0 loads o_issue every cycle. o_retire = bit 2, i.e. asserted 3 cycles after issue.
- **Perf counter.** o_stall_cnt increments on each cycle with o_stall = 1 and saturates at all-ones.

Decomposition:
- Package hazard_pkg holds:
  - REG_CNT = 32, SB_CNT_W = 2, WB_DIST = 3;
  - function cnt_init(RF_BYPASS);
  - typedef pipe_ctrl_t, a packed struct of pc_en, ifid_en, ifid_flush, idex_flush.
- One sub-module, sb_entry: a single scoreboard counter with load and decrement. Instantiated 31 times under a generate loop for r = 1..31.

Test Plan:
1. Reset sequence: i_rst = 1 for 2 cycles with arbitrary inputs -> o_pc_en = 0, both flushes = 1, o_busy_mask = 0, o_stall_cnt = 0.
2. RAW, RF_BYPASS = 1: issue add x5 at t, then ID holds sub x6,x5,x1 -> o_stall = 1 at t+1 and t+2, o_issue = 1 at t+3, o_stall_cnt = 2, o_retire = 1 at t+3 and t+6.
3. Same sequence with RF_BYPASS = 0 -> 3 stall cycles, dependent issues at t+4, o_stall_cnt = 3.
4. x0 and unused source: producer writes x0, consumer reads x0; separately consumer has rs2 = busy register but i_id_rs2_used = 0 -> no stall, o_busy_mask stays 0 for the x0 case.
5. Redirect during a stall: x5 pending and i_ex_redirect = 1 in the same cycle -> o_ifid_flush = 1, o_idex_flush = 1, o_pc_en = 1, o_stall = 0, o_issue = 0, counter[5] keeps decrementing to 0.
6. WAW then reset: issue x7 at t and t+1, check o_busy_mask[7] clear after t+3; assert i_rst at t+2 -> mask = 0 at t+3 and no retire pulses follow.
